// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colours and types for the image layer.
package vga_pkg;

  // 640x480 @ 60 Hz timing
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [2:0] rgb3_t;

  localparam rgb3_t BLACK = 3'b000;
  localparam rgb3_t WHITE = 3'b111;
  localparam rgb3_t GREEN = 3'b010;

  // Display-bank swap FSM states
  typedef enum logic [0:0] {StIdle, StSwap} swap_state_e;

  function automatic logic is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/vga_image_renderer_if.sv
// Beam, RAM and video-output bundle between the timing/RAM side and the image layer.
interface vga_image_renderer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PIX_W  = 1
);
  import vga_pkg::*;

  logic [9:0]        counter_x;
  logic [9:0]        counter_y;
  logic              in_display_area;
  logic              hsync_in;
  logic              vsync_in;
  logic              img_enable;
  logic              invert;
  logic              swap_req;
  logic [PIX_W-1:0]  ram_q;
  logic [ADDR_W:0]   rdaddress;
  logic              wr_bank;
  logic              swap_ack;
  rgb3_t             pixel;
  logic              hsync_out;
  logic              vsync_out;

  modport master (
    output counter_x, counter_y, in_display_area, hsync_in, vsync_in,
    output img_enable, invert, swap_req, ram_q,
    input  rdaddress, wr_bank, swap_ack, pixel, hsync_out, vsync_out
  );

  modport slave (
    input  counter_x, counter_y, in_display_area, hsync_in, vsync_in,
    input  img_enable, invert, swap_req, ram_q,
    output rdaddress, wr_bank, swap_ack, pixel, hsync_out, vsync_out
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a programmable value.
module vga_delay_line #(
  parameter int unsigned       Width    = 1,
  parameter int unsigned       Depth    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  import vga_pkg::*;

  if (Depth < 1) begin : g_bad_depth
    $error("vga_delay_line: Depth must be at least 1");
  end

  logic [Width-1:0] stage_q [Depth];

  // Shift every stage by one each cycle; reset loads all stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_image_renderer.sv
// Image layer: positions a scaled frame-RAM image on screen, colour-maps it,
// keeps sync aligned with the pixel pipeline and swaps display banks at frame end.
module vga_image_renderer #(
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned PIX_W      = 1,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned ORIGIN_X   = 0,
  parameter int unsigned ORIGIN_Y   = 0,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [2:0]  BG_COLOR   = 3'b010,
  parameter logic        SYNC_IDLE  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  vga_image_renderer_if.slave  bus
);
  import vga_pkg::*;

  localparam int unsigned XW       = $clog2(IMG_W);
  localparam int unsigned YW       = $clog2(IMG_H);
  localparam int unsigned Lat      = RAM_LAT + 2;
  localparam int unsigned ImgWDisp = IMG_W << SCALE_LOG2;
  localparam int unsigned ImgHDisp = IMG_H << SCALE_LOG2;

  if (PIX_W != 1 && PIX_W != 3) begin : g_bad_pix_w
    $error("vga_image_renderer: PIX_W must be 1 or 3");
  end
  if (!is_pow2(IMG_W) || !is_pow2(IMG_H)) begin : g_bad_dims
    $error("vga_image_renderer: IMG_W and IMG_H must be powers of two");
  end
  if (ADDR_W != XW + YW) begin : g_bad_addr_w
    $error("vga_image_renderer: ADDR_W must equal log2(IMG_W)+log2(IMG_H)");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_ram_lat
    $error("vga_image_renderer: RAM_LAT must be 1..3");
  end

  // Region test and address
  logic [10:0]   dx, dy;        // MSB set means beam is left of / above the origin
  logic          in_img;
  logic [XW-1:0] addr_x;
  logic [YW-1:0] addr_y;

  // Position-derived image coordinates; scaling is just a right shift.
  always_comb begin
    dx     = {1'b0, bus.counter_x} - 11'(ORIGIN_X);
    dy     = {1'b0, bus.counter_y} - 11'(ORIGIN_Y);
    in_img = !dx[10] && (32'(dx[9:0]) < ImgWDisp) &&
             !dy[10] && (32'(dy[9:0]) < ImgHDisp) && bus.in_display_area;
    addr_x = XW'(dx[9:0] >> SCALE_LOG2);
    addr_y = YW'(dy[9:0] >> SCALE_LOG2);
  end

  // Bank swap
  swap_state_e state_q;
  logic        bank_q;
  logic        swap_ack_q;
  logic        frame_end;

  assign frame_end = (bus.counter_x == 10'd0) && (bus.counter_y == 10'(V_ACTIVE));

  // Toggle the display bank once per request, only at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bank_q     <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_end && bus.swap_req) begin
            bank_q     <= ~bank_q;
            swap_ack_q <= 1'b1;
            state_q    <= StSwap;
          end
        end
        StSwap: begin
          if (!bus.swap_req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage A: RAM address plus the per-pixel flags
  logic [ADDR_W:0] rdaddr_q;
  logic [3:0]      a_flags_q;  // {in_img, in_display_area, img_enable, invert}

  // Register the read address and flags together so they stay paired.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdaddr_q  <= '0;
      a_flags_q <= '0;
    end else begin
      rdaddr_q  <= in_img ? {bank_q, addr_y, addr_x} : {bank_q, {ADDR_W{1'b0}}};
      a_flags_q <= {in_img, bus.in_display_area, bus.img_enable, bus.invert};
    end
  end

  // Flags wait out the RAM read latency
  logic [3:0] f_flags;

  vga_delay_line #(
    .Width    (4),
    .Depth    (RAM_LAT),
    .ResetVal (4'b0000)
  ) u_flag_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (a_flags_q),
    .q_o   (f_flags)
  );

  // Syncs travel the whole pipeline depth so they line up with pixel
  logic [1:0] sync_dly;

  vga_delay_line #(
    .Width    (2),
    .Depth    (Lat),
    .ResetVal ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   ({bus.hsync_in, bus.vsync_in}),
    .q_o   (sync_dly)
  );

  // Colour map
  rgb3_t img_c;

  if (PIX_W == 1) begin : g_mono
    assign img_c = {3{bus.ram_q[0]}};
  end else begin : g_rgb
    assign img_c = rgb3_t'(bus.ram_q);
  end

  rgb3_t pixel_d, pixel_q;

  // Black outside the display, background where the image is absent or disabled.
  always_comb begin
    pixel_d = BLACK;
    if (!f_flags[2]) begin
      pixel_d = BLACK;
    end else if (!f_flags[3] || !f_flags[1]) begin
      pixel_d = BG_COLOR;
    end else begin
      pixel_d = img_c ^ {3{f_flags[0]}};
    end
  end

  // Final output register.
  always_ff @(posedge clk) begin
    if (reset) pixel_q <= BLACK;
    else       pixel_q <= pixel_d;
  end

  assign bus.rdaddress = rdaddr_q;
  assign bus.wr_bank   = ~bank_q;
  assign bus.swap_ack  = swap_ack_q;
  assign bus.pixel     = pixel_q;
  assign bus.hsync_out = sync_dly[1];
  assign bus.vsync_out = sync_dly[0];

endmodule

// File: tb/tb_vga_image_renderer.sv
// Self-checking bench: two renderer configurations fed the same beam stimulus,
// each checked every cycle against a position-based reference model.
module tb_vga_image_renderer;

  localparam int MAXC = 4096;
  localparam int LA   = 3;   // RAM_LAT 1
  localparam int LB   = 5;   // RAM_LAT 3

  localparam int S_RA = 0, S_PA = 1, S_HA = 2, S_VA = 3, S_ACK = 4, S_WB = 5;
  localparam int S_RB = 6, S_PB = 7, S_HB = 8, S_RAMSB = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_image_renderer_if #(.ADDR_W(12), .PIX_W(1)) ifa ();
  vga_image_renderer_if #(.ADDR_W(12), .PIX_W(3)) ifb ();

  vga_image_renderer #(
    .IMG_W(64), .IMG_H(64), .ADDR_W(12), .PIX_W(1), .SCALE_LOG2(0),
    .ORIGIN_X(0), .ORIGIN_Y(0), .RAM_LAT(1), .V_ACTIVE(480),
    .BG_COLOR(3'b010), .SYNC_IDLE(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa)
  );

  vga_image_renderer #(
    .IMG_W(64), .IMG_H(64), .ADDR_W(12), .PIX_W(3), .SCALE_LOG2(1),
    .ORIGIN_X(100), .ORIGIN_Y(50), .RAM_LAT(3), .V_ACTIVE(480),
    .BG_COLOR(3'b010), .SYNC_IDLE(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb)
  );

  // Frame RAMs (both banks) and their read pipelines
  bit         mem_a [8192];
  logic [2:0] mem_b [8192];
  logic [0:0] qa;
  logic [2:0] qb_pipe [3];

  always @(posedge clk) begin
    qa         <= mem_a[ifa.rdaddress];
    qb_pipe[0] <= mem_b[ifb.rdaddress];
    qb_pipe[1] <= qb_pipe[0];
    qb_pipe[2] <= qb_pipe[1];
  end
  assign ifa.ram_q = qa;
  assign ifb.ram_q = qb_pipe[2];

  // Stimulus history and bank model
  typedef struct {
    int cx, cy;
    bit da, hs, vs, en, inv, req, rst, bank, tog;
  } hrec_t;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string nm;
  } lit_t;

  hrec_t hist [MAXC];
  lit_t  lits [$];
  int    n = 0;
  int    dcyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    m_bank = 1'b0;
  bit    m_served = 1'b0;

  int d_cx = 0, d_cy = 0;
  bit d_da = 0, d_hs = 1, d_vs = 1, d_en = 0, d_inv = 0, d_req = 0, d_rst = 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", nm, n, act, exp);
    end
  endtask

  function automatic bit img_hit(int d, hrec_t r);
    int ox = (d == 0) ? 0 : 100;
    int oy = (d == 0) ? 0 : 50;
    int s  = (d == 0) ? 0 : 1;
    return r.da && r.cx >= ox && (r.cx - ox) < (64 << s) &&
           r.cy >= oy && (r.cy - oy) < (64 << s);
  endfunction

  function automatic int exp_addr(int d, hrec_t r);
    int ox = (d == 0) ? 0 : 100;
    int oy = (d == 0) ? 0 : 50;
    int s  = (d == 0) ? 0 : 1;
    int base = r.bank ? 4096 : 0;
    if (!img_hit(d, r)) return base;
    return base + ((r.cy - oy) >> s) * 64 + ((r.cx - ox) >> s);
  endfunction

  function automatic int exp_pix(int d, hrec_t r);
    int c;
    int a;
    if (!r.da) return 0;
    if (!img_hit(d, r) || !r.en) return 2;
    a = exp_addr(d, r);
    c = (d == 0) ? (mem_a[a] ? 7 : 0) : int'(mem_b[a]);
    return r.inv ? (c ^ 7) : c;
  endfunction

  function automatic bit any_rst(int lo, int hi);
    for (int i = lo; i <= hi; i++) if (hist[i].rst) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int get_sel(int sel);
    case (sel)
      S_RA:    return int'(ifa.rdaddress);
      S_PA:    return int'(ifa.pixel);
      S_HA:    return int'(ifa.hsync_out);
      S_VA:    return int'(ifa.vsync_out);
      S_ACK:   return int'(ifa.swap_ack);
      S_WB:    return int'(ifa.wr_bank);
      S_RB:    return int'(ifb.rdaddress);
      S_PB:    return int'(ifb.pixel);
      S_HB:    return int'(ifb.hsync_out);
      default: return int'(ifa.rdaddress[12]);
    endcase
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    hrec_t r;
    hrec_t p;
    bit    tog;
    if (n < MAXC) begin
      r.cx = d_cx; r.cy = d_cy; r.da = d_da; r.hs = d_hs; r.vs = d_vs;
      r.en = d_en; r.inv = d_inv; r.req = d_req; r.rst = d_rst;
      r.bank = m_bank; r.tog = 1'b0;
      hist[n] = r;

      if (n >= 1) begin
        p = hist[n-1];
        chk("rdaddr_a", int'(ifa.rdaddress), p.rst ? 0 : exp_addr(0, p));
        chk("rdaddr_b", int'(ifb.rdaddress), p.rst ? 0 : exp_addr(1, p));
        chk("swap_ack_a", int'(ifa.swap_ack), int'(p.tog));
        chk("swap_ack_b", int'(ifb.swap_ack), int'(p.tog));
        chk("wr_bank_a", int'(ifa.wr_bank), int'(!m_bank));
        chk("wr_bank_b", int'(ifb.wr_bank), int'(!m_bank));
      end
      if (n >= LA) begin
        p = hist[n-LA];
        if (any_rst(n - LA, n - 1)) begin
          chk("pixel_a", int'(ifa.pixel), 0);
          chk("hsync_a", int'(ifa.hsync_out), 1);
          chk("vsync_a", int'(ifa.vsync_out), 1);
        end else begin
          chk("pixel_a", int'(ifa.pixel), exp_pix(0, p));
          chk("hsync_a", int'(ifa.hsync_out), int'(p.hs));
          chk("vsync_a", int'(ifa.vsync_out), int'(p.vs));
        end
      end
      if (n >= LB) begin
        p = hist[n-LB];
        if (any_rst(n - LB, n - 1)) begin
          chk("pixel_b", int'(ifb.pixel), 0);
          chk("hsync_b", int'(ifb.hsync_out), 1);
          chk("vsync_b", int'(ifb.vsync_out), 1);
        end else begin
          chk("pixel_b", int'(ifb.pixel), exp_pix(1, p));
          chk("hsync_b", int'(ifb.hsync_out), int'(p.hs));
          chk("vsync_b", int'(ifb.vsync_out), int'(p.vs));
        end
      end

      foreach (lits[i]) begin
        if (lits[i].cyc == n) chk(lits[i].nm, get_sel(lits[i].sel), lits[i].val);
      end

      // One bank toggle per request, only on the first boundary it is seen at.
      tog = !r.rst && r.cx == 0 && r.cy == 480 && r.req && !m_served;
      m_served = !r.rst && (tog || (m_served && r.req));
      m_bank = r.rst ? 1'b0 : (m_bank ^ tog);
      hist[n].tog = tog;
    end
    n++;
  end

  task automatic drive(int cx, int cy, bit da, bit hs, bit vs, bit en, bit inv, bit req, bit r);
    @(posedge clk);
    #1;
    dcyc = n;
    d_cx = cx; d_cy = cy; d_da = da; d_hs = hs; d_vs = vs;
    d_en = en; d_inv = inv; d_req = req; d_rst = r;
    rst = r;
    ifa.counter_x = 10'(cx); ifb.counter_x = 10'(cx);
    ifa.counter_y = 10'(cy); ifb.counter_y = 10'(cy);
    ifa.in_display_area = da; ifb.in_display_area = da;
    ifa.hsync_in = hs; ifb.hsync_in = hs;
    ifa.vsync_in = vs; ifb.vsync_in = vs;
    ifa.img_enable = en; ifb.img_enable = en;
    ifa.invert = inv; ifb.invert = inv;
    ifa.swap_req = req; ifb.swap_req = req;
  endtask

  task automatic lit(int off, int sel, int val, string nm);
    lits.push_back('{dcyc + off, sel, val, nm});
  endtask

  initial begin
    bit req;
    bit en;
    bit inv;
    int rst_left;

    for (int a = 0; a < 8192; a++) begin
      mem_a[a] = bit'(a & 1) ^ bit'((a >> 12) & 1);
      mem_b[a] = 3'($urandom_range(0, 7));
    end
    mem_b[0] = 3'b101;

    ifa.counter_x = '0; ifb.counter_x = '0;
    ifa.counter_y = '0; ifb.counter_y = '0;
    ifa.in_display_area = 1'b0; ifb.in_display_area = 1'b0;
    ifa.hsync_in = 1'b1; ifb.hsync_in = 1'b1;
    ifa.vsync_in = 1'b1; ifb.vsync_in = 1'b1;
    ifa.img_enable = 1'b0; ifb.img_enable = 1'b0;
    ifa.invert = 1'b0; ifb.invert = 1'b0;
    ifa.swap_req = 1'b0; ifb.swap_req = 1'b0;

    repeat (4) drive(0, 0, 0, 1, 1, 0, 0, 0, 1);

    // Unscaled image at the origin
    drive(0, 0, 1, 1, 1, 1, 0, 0, 0);  lit(1, S_RA, 0, "lit_addr_0_0");  lit(3, S_PA, 0, "lit_pix_0_0");
    drive(1, 0, 1, 1, 1, 1, 0, 0, 0);  lit(1, S_RA, 1, "lit_addr_1_0");  lit(3, S_PA, 7, "lit_pix_1_0");
    drive(63, 0, 1, 1, 1, 1, 0, 0, 0); lit(1, S_RA, 63, "lit_addr_63_0"); lit(3, S_PA, 7, "lit_pix_63_0");
    drive(64, 0, 1, 1, 1, 1, 0, 0, 0); lit(3, S_PA, 2, "lit_pix_64_0_bg");

    // Scaled, offset image
    drive(100, 50, 1, 1, 1, 1, 0, 0, 0); lit(1, S_RB, 0, "lit_b_addr_100_50"); lit(5, S_PB, 5, "lit_b_pix_100_50");
    drive(101, 50, 1, 1, 1, 1, 0, 0, 0); lit(1, S_RB, 0, "lit_b_addr_101_50");
    drive(102, 50, 1, 1, 1, 1, 0, 0, 0); lit(1, S_RB, 1, "lit_b_addr_102_50");
    drive(227, 177, 1, 1, 1, 1, 0, 0, 0); lit(1, S_RB, 4095, "lit_b_addr_227_177");
    drive(228, 50, 1, 1, 1, 1, 0, 0, 0); lit(5, S_PB, 2, "lit_b_pix_228_50_bg");
    drive(100, 50, 1, 1, 1, 1, 1, 0, 0); lit(5, S_PB, 2, "lit_b_pix_invert_in");
    drive(228, 50, 1, 1, 1, 1, 1, 0, 0); lit(5, S_PB, 2, "lit_b_pix_invert_out");

    // hsync edge must emerge 5 cycles later, with that beam's pixel
    drive(100, 50, 1, 0, 1, 1, 0, 0, 0);
    lit(4, S_HB, 1, "lit_b_hsync_before"); lit(5, S_HB, 0, "lit_b_hsync_after");
    lit(5, S_PB, 5, "lit_b_pix_aligned");
    repeat (3) drive(101, 50, 1, 0, 1, 1, 0, 0, 0);

    // Mid-frame request waits for the frame boundary
    drive(10, 200, 1, 1, 1, 1, 0, 1, 0); lit(1, S_ACK, 0, "lit_ack_midframe"); lit(1, S_WB, 1, "lit_wb_midframe");
    repeat (2) drive(10, 200, 1, 1, 1, 1, 0, 1, 0);
    drive(0, 480, 0, 1, 1, 1, 0, 1, 0);
    lit(1, S_ACK, 1, "lit_ack_pulse"); lit(1, S_WB, 0, "lit_wb_after_swap");
    lit(2, S_ACK, 0, "lit_ack_single"); lit(2, S_RAMSB, 1, "lit_addr_msb_bank1");
    repeat (2) drive(1, 480, 0, 1, 1, 1, 0, 1, 0);
    for (int f = 0; f < 2; f++) begin
      drive(0, 480, 0, 1, 1, 1, 0, 1, 0);
      lit(1, S_ACK, 0, "lit_ack_held_req"); lit(1, S_WB, 0, "lit_wb_held_req");
      repeat (3) drive(5, 10, 1, 1, 1, 1, 0, 1, 0);
    end

    // Reset mid-frame with bank 1
    repeat (4) drive(20, 300, 1, 0, 0, 1, 0, 1, 0);
    drive(20, 300, 1, 0, 0, 1, 0, 1, 1);
    lit(1, S_PA, 0, "lit_rst_pixel"); lit(1, S_HA, 1, "lit_rst_hsync"); lit(1, S_VA, 1, "lit_rst_vsync");
    lit(1, S_WB, 1, "lit_rst_bank"); lit(1, S_ACK, 0, "lit_rst_ack");
    drive(1, 0, 1, 0, 0, 1, 0, 1, 0);
    lit(2, S_PA, 0, "lit_rel_pix_early"); lit(3, S_PA, 7, "lit_rel_pix_valid");
    repeat (4) drive(2, 0, 1, 0, 0, 1, 0, 1, 0);

    // Randomized traffic
    req = 1'b1; en = 1'b1; inv = 1'b0; rst_left = 0;
    for (int k = 0; k < 2500; k++) begin
      int cx;
      int cy;
      int pick;
      bit r;
      pick = int'($urandom_range(0, 9));
      if (pick == 0) begin
        cx = 0; cy = 480;
      end else if (pick < 4) begin
        cx = int'($urandom_range(0, 70)); cy = int'($urandom_range(0, 70));
      end else if (pick < 7) begin
        cx = int'($urandom_range(90, 240)); cy = int'($urandom_range(40, 190));
      end else begin
        cx = int'($urandom_range(0, 799)); cy = int'($urandom_range(0, 524));
      end
      if ($urandom_range(0, 15) == 0) req = !req;
      if ($urandom_range(0, 31) == 0) en = !en;
      if ($urandom_range(0, 15) == 0) inv = !inv;
      if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = int'($urandom_range(1, 3));
      r = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      drive(cx, cy, (cx < 640) && (cy < 480), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) != 0, en, inv, req, r);
    end

    repeat (8) drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
